change_dispenser: RTL
=====================

# change_dispenser

Return-side counterpart of the vending machine's per-cycle total/item calculation: takes a return amount and pays it out as physical coins, one coin per cycle, greedy largest-first, through a ready-gated coin hopper. Sits between the top-level return path (return request and amount) and the coin hopper driver. It reports coins paid out, the running returned total, and shortfall when exact change is impossible.

## Interface
Parameters:
- COIN_VAL0, 100, value of coin 0 (smallest)
- COIN_VAL1, 500, value of coin 1
- COIN_VAL2, 1000, value of coin 2 (largest)
- STOCK_BITS, 8, width of each per-coin stock counter
- STOCK_INIT, 4, stock count of every coin after reset

Widths `kTotalBits` and `kNumCoins` (=3) come from vending_machine_def.v.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- i_return_req  in  1  start a return; accepted only in IDLE
- i_return_amount  in  kTotalBits  amount to return; sampled on accept
- i_hopper_ready  in  1  hopper can take a coin this cycle
- i_refill  in  kNumCoins  per-coin +1 stock pulse
- o_return_coin  out  kNumCoins  one-hot coin dispensed this cycle, or zero
- o_busy  out  1  high in DISPENSE and DONE
- o_done  out  1  one-cycle pulse ending a transaction
- o_shortfall  out  1  last transaction ended with remaining != 0
- o_return_total  out  kTotalBits  sum dispensed in current/last transaction
- o_remaining  out  kTotalBits  amount still owed

## Operation
- States: IDLE, DISPENSE, DONE. Reset: IDLE, all outputs 0, remaining 0, return_total 0, every stock = STOCK_INIT.
- IDLE: i_return_req=1 -> latch remaining = i_return_amount, clear return_total and shortfall, go DISPENSE. Requests in other states are ignored (not queued).
- DISPENSE, each cycle: eligible coin k = largest with COIN_VALk <= remaining and stock[k] != 0.
  - Eligible coin exists, i_hopper_ready=1: o_return_coin = one-hot k (combinational, same cycle); at edge remaining -= COIN_VALk, return_total += COIN_VALk, stock[k] -= 1.
  - Eligible coin exists, i_hopper_ready=0: o_return_coin=0, hold state (stall).
  - No eligible coin (including remaining==0): o_return_coin=0, go DONE; shortfall <= (remaining != 0).
- DONE: o_done=1 for exactly one cycle, go IDLE. o_return_total, o_remaining, o_shortfall hold until the next accept.
- Refill: i_refill[k]=1 -> stock[k] += 1, saturating at 2^STOCK_BITS-1. Same-cycle refill and dispense of coin k -> stock[k] unchanged. Refill is honoured in every state.
- Arithmetic: unsigned, kTotalBits; remaining never underflows because of the eligibility rule.

## Timing
- Accept at edge E0; DISPENSE from cycle 1. With ready held high, N coins appear in cycles 1..N, and cycle N+1 detects no eligible coin. o_done is high in cycle N+2, and the block is back in IDLE at cycle N+3.
- Ready-low cycles extend DISPENSE one-for-one; no coin is lost or duplicated.
- Amount 0: DISPENSE one cycle, o_done in cycle 2, no shortfall.
- Reset mid-transaction: immediate return to IDLE, coin output drops asynchronously, totals cleared, stock reinitialised.

## Configuration
- CHANGE_STOCK_EN defined: per-coin stock counters implemented as above; i_refill active.
- Not defined: no stock counters; every coin is always treated as in stock; i_refill ignored; shortfall only occurs when remaining is not a multiple reachable by coin values (e.g. below COIN_VAL0).

## Test plan
- Return 1600, ready high -> coins 1000, 500, 100 in cycles 1-3; o_done cycle 5; return_total 1600, remaining 0, shortfall 0.
- Return 250 -> 100, 100, then DONE with remaining 50, shortfall 1, return_total 200.
- Return 600, ready low cycles 1-3 -> no coin until ready; 500 then 100 once ready, exact totals, no extra coins.
- CHANGE_STOCK_EN, coin-2 stock 0, return 1000 -> 500, 500; stock1 decremented by 2; refill pulse on coin 2 then return 1000 -> single 1000.
- Reset asserted after first coin of 1600 -> outputs 0 immediately; a new request of 100 completes normally with stock back to STOCK_INIT.
- Return 0 -> no coins, o_done cycle 2, shortfall 0; i_return_req pulses in DISPENSE are ignored.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: greedy largest-first coin payout, one coin per cycle,
// gated by the hopper's ready signal.
//
// Optional feature macro: CHANGE_STOCK_EN
//   defined   -> per-coin stock counters, i_refill honoured
//   undefined -> every coin always available, i_refill ignored
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-high
//   i_return_req     start a return (accepted only in IDLE)
//   i_return_amount  amount to return, sampled on accept
//   i_hopper_ready   hopper can take a coin this cycle
//   i_refill         per-coin +1 stock pulse
//   o_return_coin    one-hot coin dispensed this cycle, or zero
//   o_busy           high in DISPENSE and DONE
//   o_done           one-cycle pulse ending a transaction
//   o_shortfall      last transaction ended with an unpaid remainder
//   o_return_total   sum dispensed in the current/last transaction
//   o_remaining      amount still owed
module change_dispenser #(
    parameter int COIN_VAL0  = 100,
    parameter int COIN_VAL1  = 500,
    parameter int COIN_VAL2  = 1000,
    parameter int STOCK_BITS = 8,
    parameter int STOCK_INIT = 4,
    parameter int kTotalBits = 16,
    parameter int kNumCoins  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_return_req,
    input  logic [kTotalBits-1:0] i_return_amount,
    input  logic                  i_hopper_ready,
    input  logic [kNumCoins-1:0]  i_refill,
    output logic [kNumCoins-1:0]  o_return_coin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_shortfall,
    output logic [kTotalBits-1:0] o_return_total,
    output logic [kTotalBits-1:0] o_remaining
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    localparam logic [kTotalBits-1:0] VAL0 = kTotalBits'(COIN_VAL0);
    localparam logic [kTotalBits-1:0] VAL1 = kTotalBits'(COIN_VAL1);
    localparam logic [kTotalBits-1:0] VAL2 = kTotalBits'(COIN_VAL2);

    state_t                  state_q;
    state_t                  state_d;
    logic [kTotalBits-1:0]   remaining_q;
    logic [kTotalBits-1:0]   total_q;
    logic                    shortfall_q;

    logic [kNumCoins-1:0]    in_stock;
    logic [kNumCoins-1:0]    fits;
    logic [kNumCoins-1:0]    pick;
    logic [kTotalBits-1:0]   pick_val;
    logic                    any_fit;
    logic [kNumCoins-1:0]    take;

    // ------------------------------------------------------------------
    // Stock tracking
    // ------------------------------------------------------------------
`ifdef CHANGE_STOCK_EN
    localparam logic [STOCK_BITS-1:0] STOCK_MAX = '1;
    localparam logic [STOCK_BITS-1:0] STOCK_RST = STOCK_BITS'(STOCK_INIT);

    logic [STOCK_BITS-1:0] stock_q [kNumCoins];

    always_comb begin
        in_stock = '0;
        for (int k = 0; k < kNumCoins; k++) begin
            in_stock[k] = (stock_q[k] != '0);
        end
    end

    // Refill and dispense of the same coin in one cycle cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < kNumCoins; k++) begin
                stock_q[k] <= STOCK_RST;
            end
        end else begin
            for (int k = 0; k < kNumCoins; k++) begin
                case ({i_refill[k], take[k]})
                    2'b10: begin
                        if (stock_q[k] != STOCK_MAX) begin
                            stock_q[k] <= stock_q[k] + 1'b1;
                        end
                    end
                    2'b01:   stock_q[k] <= stock_q[k] - 1'b1;
                    default: stock_q[k] <= stock_q[k];
                endcase
            end
        end
    end
`else
    logic unused_refill;

    assign in_stock      = '1;
    assign unused_refill = ^i_refill;
`endif

    // ------------------------------------------------------------------
    // Coin selection: largest value that fits and is in stock
    // ------------------------------------------------------------------
    always_comb begin
        fits    = '0;
        fits[0] = in_stock[0] && (remaining_q >= VAL0);
        fits[1] = in_stock[1] && (remaining_q >= VAL1);
        fits[2] = in_stock[2] && (remaining_q >= VAL2);
    end

    always_comb begin
        pick     = '0;
        pick_val = '0;
        if (fits[2]) begin
            pick[2]  = 1'b1;
            pick_val = VAL2;
        end else if (fits[1]) begin
            pick[1]  = 1'b1;
            pick_val = VAL1;
        end else if (fits[0]) begin
            pick[0]  = 1'b1;
            pick_val = VAL0;
        end
    end

    assign any_fit = |fits;

    // A coin leaves only when the hopper accepts it this cycle.
    assign take = ((state_q == ST_DISPENSE) && i_hopper_ready) ? pick : '0;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_return_req) begin
                    state_d = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                if (!any_fit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_return_coin = take;
        o_busy        = (state_q == ST_DISPENSE) || (state_q == ST_DONE);
        o_done        = (state_q == ST_DONE);
    end

    // ------------------------------------------------------------------
    // Amount / total / shortfall registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining_q <= '0;
            total_q     <= '0;
            shortfall_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_return_req) begin
                        remaining_q <= i_return_amount;
                        total_q     <= '0;
                        shortfall_q <= 1'b0;
                    end
                end
                ST_DISPENSE: begin
                    if (!any_fit) begin
                        shortfall_q <= (remaining_q != '0);
                    end else if (|take) begin
                        // pick_val <= remaining_q by construction
                        remaining_q <= remaining_q - pick_val;
                        total_q     <= total_q + pick_val;
                    end
                end
                default: begin
                    remaining_q <= remaining_q;
                end
            endcase
        end
    end

    assign o_shortfall    = shortfall_q;
    assign o_return_total = total_q;
    assign o_remaining    = remaining_q;

endmodule
